// File: rtl/svlib_arb_pkg.sv
// Shared helpers for SVLib arbiters: pointer rotation and index typing.
// Stateless; safe to import anywhere.
package svlib_arb_pkg;

  typedef int unsigned arb_idx_t;

  // Next round-robin pointer with an explicit wrap, so non-power-of-2 n stays in range.
  function automatic arb_idx_t rr_next(input arb_idx_t ptr, input arb_idx_t n);
    return (ptr >= n - 1) ? '0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: lowest set request at or above ptr, else wrap to lowest overall.
// A double-width vector {req, req & mask} gives both searches in one priority encode.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any_gnt
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;

  always_comb begin
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
    dbl    = {req, req & mask};
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i]) begin
        found  = 1'b1;
        gnt_id = IDW'((i >= N) ? i - N : i);
      end
    end
    any_gnt = |req;
    gnt     = '0;
    if (any_gnt) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin sharing of one regfile write port among NUM_REQ valid/ready requesters.
// The winner lands in a registered output stage that only advances when empty or consumed.
module regfile_wr_arbiter
  import svlib_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic [ID_WIDTH-1:0]            wr_id,
  input  logic                           wr_ready
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
  logic [ID_WIDTH-1:0]                ptr;
  logic [NUM_REQ-1:0]                 gnt;
  logic [ID_WIDTH-1:0]                gnt_id;
  logic                               any_gnt;
  logic                               advance;

  assign addr_v = req_addr;
  assign data_v = req_data;

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_WIDTH)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  assign advance   = ~wr_en | wr_ready;
  // Ready is withheld during reset so nothing is accepted and then lost.
  assign req_ready = (advance && any_gnt && !rst) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_id   <= '0;
      ptr     <= '0;
    end else if (advance) begin
      wr_en <= any_gnt;
      if (any_gnt) begin
        wr_addr <= addr_v[gnt_id];
        wr_data <= data_v[gnt_id];
        wr_id   <= gnt_id;
        ptr     <= ID_WIDTH'(rr_next(arb_idx_t'(gnt_id), arb_idx_t'(NUM_REQ)));
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single request, full load, backpressure,
// skip/wrap and mid-burst reset, with a scoreboard pairing accepted requests to writes.
module tb_regfile_wr_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][4:0]  addr_a;
  logic [3:0][31:0] data_a;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [1:0]       wr_id;
  logic             wr_ready;

  int n_chk  = 0;
  int n_pass = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (addr_a),
    .req_data  (data_a),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_id     (wr_id),
    .wr_ready  (wr_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: push on accept, pop on consumed write; order must match.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) sb_q.push_back({addr_a[i], data_a[i]});
    if (wr_en && wr_ready) begin
      if (sb_q.size() == 0) chk("sb_extra_write", 64'd1, 64'd0);
      else chk("sb_order", {27'd0, wr_addr, wr_data}, {27'd0, sb_q.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 5'(8 + i);
      data_a[i] = 32'h100 + 32'(i);
    end

    // 1. reset
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1 chk("rst_ready", 64'(req_ready), 64'h0);
      cyc();
    end
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    chk("rst_wr_id", 64'(wr_id), 0);

    // 2. single request
    rst = 1'b0; req_valid = 4'b0100; addr_a[2] = 5'd3; data_a[2] = 32'hA5;
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = 4'b0000;
    chk("single_wr_en", 64'(wr_en), 1);
    chk("single_wr_addr", 64'(wr_addr), 3);
    chk("single_wr_data", 64'(wr_data), 64'hA5);
    chk("single_wr_id", 64'(wr_id), 2);
    cyc();
    chk("single_wr_en_drop", 64'(wr_en), 0);

    // 3. full load from ptr=0
    rst = 1'b1; addr_a[2] = 5'd10; data_a[2] = 32'h102;
    cyc();
    rst = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("full_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cyc();
      chk("full_wr_en", 64'(wr_en), 1);
      chk("full_wr_id", 64'(wr_id), 64'(k % 4));
      chk("full_wr_addr", 64'(wr_addr), 64'(8 + k % 4));
    end

    // 4. backpressure with wr_id=1 held
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 64'(req_ready), 0);
      cyc();
      chk("bp_wr_en", 64'(wr_en), 1);
      chk("bp_wr_id", 64'(wr_id), 1);
      chk("bp_wr_addr", 64'(wr_addr), 9);
      chk("bp_wr_data", 64'(wr_data), 64'h101);
    end
    wr_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'b0100);
    cyc();
    chk("bp_release_wr_id", 64'(wr_id), 2);
    chk("bp_release_wr_data", 64'(wr_data), 64'h102);

    // 5. skip and wrap: grant 1 to park ptr at 2, then 1010 -> 3, 1, ptr=2
    req_valid = 4'b0010;
    #1 chk("wrap_setup_ready", 64'(req_ready), 64'b0010);
    cyc();
    chk("wrap_setup_id", 64'(wr_id), 1);
    req_valid = 4'b1010;
    #1 chk("wrap_ready_3", 64'(req_ready), 64'b1000);
    cyc();
    chk("wrap_wr_id_3", 64'(wr_id), 3);
    #1 chk("wrap_ready_1", 64'(req_ready), 64'b0010);
    cyc();
    chk("wrap_wr_id_1", 64'(wr_id), 1);
    #1 chk("wrap_ptr2_ready", 64'(req_ready), 64'b1000);

    // 6. reset mid-burst
    rst = 1'b1;
    #1 chk("midrst_ready", 64'(req_ready), 0);
    cyc();
    chk("midrst_wr_en", 64'(wr_en), 0);
    rst = 1'b0; req_valid = 4'b1111;
    #1 chk("midrst_first_ready", 64'(req_ready), 64'b0001);
    cyc();
    chk("midrst_first_id", 64'(wr_id), 0);
    chk("midrst_first_en", 64'(wr_en), 1);
    req_valid = 4'b0000;
    cyc();
    chk("sb_drained", 64'(sb_q.size()), 0);
    chk("idle_wr_en", 64'(wr_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
